// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package proc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Wide enough for the largest legal memory latency (15).
  localparam int CNT_W = 4;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the port arbiter.
// slave: the arbiter. master: the core datapath plus memory model.
import proc_mem_pkg::*;

interface mem_port_arbiter_if #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata,
           busy, owner
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata,
           busy, owner
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times one memory access; is_one marks the
// last BUSY cycle.
module mem_lat_counter
  import proc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; saturate at zero so an idle count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// data ld/sd. Serialises accesses, times the fixed read latency and returns
// a one-cycle ack per access.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; by
// default data has fixed priority over fetch.
//
// state | meaning
// IDLE  | no access in flight; pick a winner and latch its request
// BUSY  | memory access in progress, counter running down
// RESP  | one-cycle ack to the owner, then back to IDLE
module mem_port_arbiter
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
  end

  arb_state_t        state;
  owner_t            own_q;
  logic              lat_we;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              busy_q;

  logic              any_req;
  logic              grant_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_is_one;

`ifdef MEM_ARB_RR_EN
  // Tracks the last granted requester; only consulted when both contend.
  owner_t            last_owner;
`endif

  // Winner selection and counter load value for the grant made in IDLE.
  always_comb begin
    any_req = bus.if_req | bus.d_req;
`ifdef MEM_ARB_RR_EN
    grant_d = bus.d_req & (~bus.if_req | (last_owner == OWN_IF));
`else
    grant_d = bus.d_req;
`endif
    cnt_load     = (state == IDLE) & any_req;
    cnt_dec      = (state == BUSY);
    // A store needs a single BUSY cycle; loads and fetches wait out the latency.
    cnt_load_val = (grant_d & bus.d_we) ? CNT_W'(1) : CNT_W'(MEM_LAT);
  end

  mem_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      own_q       <= OWN_IF;
      lat_we      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner  <= OWN_IF;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= BUSY;
            busy_q <= 1'b1;
            if (grant_d) begin
              own_q       <= OWN_D;
              lat_we      <= bus.d_we;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              own_q      <= OWN_IF;
              lat_we     <= 1'b0;
              mem_addr_q <= bus.if_addr;
            end
`ifdef MEM_ARB_RR_EN
            last_owner <= grant_d ? OWN_D : OWN_IF;
`endif
          end
        end
        BUSY: begin
          if (cnt_is_one) begin
            state <= RESP;
            if (own_q == OWN_D) begin
              d_ack_q <= 1'b1;
              if (!lat_we) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = own_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks,
// monitors pop and compare whenever an ack appears.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import proc_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus5 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(5)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5));

  // Memory contents: one preloaded word, a fixed pattern elsewhere.
  function automatic logic [63:0] mem_val(input logic [31:0] a);
    if (a == 32'h40) return 64'hDEAD_BEEF_0000_0001;
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  // Read data becomes valid in the MEM_LAT-th cycle of address presentation.
  logic [63:0] rd2;
  logic [63:0] p5 [4];
  always @(posedge clk) rd2 <= mem_val(bus.mem_addr);
  assign bus.mem_rdata  = rd2;
  assign bus1.mem_rdata = mem_val(bus1.mem_addr);
  always @(posedge clk) begin
    p5[0] <= mem_val(bus5.mem_addr);
    for (int i = 1; i < 4; i++) p5[i] <= p5[i-1];
  end
  assign bus5.mem_rdata = p5[3];

  typedef struct {
    bit          is_d;
    int          cyc;
    logic [63:0] rdata;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t q1[$];
  exp_t q5[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input bit is_d, input int c, input logic [63:0] rd, input bit chk);
    exp_t e;
    e.is_d = is_d; e.cyc = c; e.rdata = rd; e.chk_data = chk;
    return e;
  endfunction

  // Main-instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_ack || bus.d_ack) begin
      check("one_ack_only", {63'd0, bus.if_ack & bus.d_ack}, 64'd0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_ack");
      end else begin
        e = exp_q.pop_front();
        check("ack_kind", {63'd0, bus.d_ack}, {63'd0, e.is_d});
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        check("ack_owner", {63'd0, bus.owner}, {63'd0, e.is_d});
        if (e.chk_data)
          check(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
      end
    end
  end

  // MEM_LAT=1 instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.if_ack || bus1.d_ack) begin
      check("lat1_no_dack", {63'd0, bus1.d_ack}, 64'd0);
      if (q1.size() == 0) begin
        fail_now("lat1_unexpected_ack");
      end else begin
        e = q1.pop_front();
        check("lat1_ack_cycle", 64'(cyc), 64'(e.cyc));
        check("lat1_if_rdata", bus1.if_rdata, e.rdata);
      end
    end
  end

  // MEM_LAT=5 instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (bus5.if_ack || bus5.d_ack) begin
      check("lat5_no_dack", {63'd0, bus5.d_ack}, 64'd0);
      if (q5.size() == 0) begin
        fail_now("lat5_unexpected_ack");
      end else begin
        e = q5.pop_front();
        check("lat5_ack_cycle", 64'(cyc), 64'(e.cyc));
        check("lat5_if_rdata", bus5.if_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    bus.if_req  = 0; bus.if_addr  = '0; bus.d_req  = 0; bus.d_we  = 0; bus.d_addr  = '0; bus.d_wdata  = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus5.if_req = 0; bus5.if_addr = '0; bus5.d_req = 0; bus5.d_we = 0; bus5.d_addr = '0; bus5.d_wdata = '0;

    // Reset values.
    repeat (3) step();
    @(negedge clk);
    check("rst_busy",     {63'd0, bus.busy},   64'd0);
    check("rst_owner",    {63'd0, bus.owner},  64'd0);
    check("rst_mem_we",   {63'd0, bus.mem_we}, 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr),   64'd0);
    check("rst_if_rdata", bus.if_rdata,        64'd0);
    check("rst_d_rdata",  bus.d_rdata,         64'd0);
    check("rst_acks",     {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
    step();
    reset = 0;
    step();

    // Single load from 0x40.
    step(); t0 = cyc;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    exp_q.push_back(mk(1, t0 + 3, 64'hDEAD_BEEF_0000_0001, 1));
    @(negedge clk); check("ld_busy_c0", {63'd0, bus.busy}, 64'd0);
    step(); @(negedge clk);
    check("ld_busy_c1", {63'd0, bus.busy}, 64'd1);
    check("ld_mem_addr", 64'(bus.mem_addr), 64'h40);
    check("ld_mem_we", {63'd0, bus.mem_we}, 64'd0);
    step(); @(negedge clk);
    check("ld_busy_c2", {63'd0, bus.busy}, 64'd1);
    check("ld_no_early_ack", {63'd0, bus.d_ack}, 64'd0);
    step(); bus.d_req = 0;
    @(negedge clk); check("ld_if_ack_low", {63'd0, bus.if_ack}, 64'd0);
    step(); @(negedge clk); check("ld_busy_idle", {63'd0, bus.busy}, 64'd0);

    // Single store of 0x1234 to 0x80.
    step(); t0 = cyc;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_wdata = 64'h1234;
    exp_q.push_back(mk(1, t0 + 2, 64'd0, 0));
    @(negedge clk); check("st_we_c0", {63'd0, bus.mem_we}, 64'd0);
    step(); @(negedge clk);
    check("st_we_c1", {63'd0, bus.mem_we}, 64'd1);
    check("st_mem_addr", 64'(bus.mem_addr), 64'h80);
    check("st_mem_wdata", bus.mem_wdata, 64'h1234);
    step(); bus.d_req = 0; bus.d_we = 0;
    @(negedge clk); check("st_we_c2", {63'd0, bus.mem_we}, 64'd0);
    step();

    // Both requesters rise together.
    step(); t0 = cyc;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req  = 1; bus.d_we = 0; bus.d_addr = 32'h48;
`ifndef MEM_ARB_RR_EN
    exp_q.push_back(mk(1, t0 + 3, 64'hC0DE_0048_FFFF_FFB7, 1));
    exp_q.push_back(mk(0, t0 + 7, 64'hC0DE_0100_FFFF_FEFF, 1));
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) bus.d_req = 0;
      if (k == 7) bus.if_req = 0;
      @(negedge clk);
      if (k == 1) check("sim_owner_data", {63'd0, bus.owner}, 64'd1);
      if (k == 3) check("sim_if_rdata_held", bus.if_rdata, 64'd0);
      if (k == 7) check("sim_d_rdata_held", bus.d_rdata, 64'hC0DE_0048_FFFF_FFB7);
    end
`else
    // Last grant was data, so the rotation starts with fetch.
    exp_q.push_back(mk(0, t0 + 3,  64'hC0DE_0100_FFFF_FEFF, 1));
    exp_q.push_back(mk(1, t0 + 7,  64'hC0DE_0048_FFFF_FFB7, 1));
    exp_q.push_back(mk(0, t0 + 11, 64'hC0DE_0100_FFFF_FEFF, 1));
    exp_q.push_back(mk(1, t0 + 15, 64'hC0DE_0048_FFFF_FFB7, 1));
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin bus.if_req = 0; bus.d_req = 0; end
      @(negedge clk);
      if (k == 1) check("rr_owner_fetch", {63'd0, bus.owner}, 64'd0);
      if (k == 5) check("rr_owner_data",  {63'd0, bus.owner}, 64'd1);
    end
`endif

    // Reset during the first BUSY cycle of a store.
    step(); t0 = cyc;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h90; bus.d_wdata = 64'h55;
    step(); @(negedge clk);
    check("rst_st_we_c1", {63'd0, bus.mem_we}, 64'd1);
    reset = 1;
    step();
    reset = 0; bus.d_req = 0; bus.d_we = 0;
    @(negedge clk);
    check("abort_mem_we",    {63'd0, bus.mem_we}, 64'd0);
    check("abort_mem_addr",  64'(bus.mem_addr),   64'd0);
    check("abort_mem_wdata", bus.mem_wdata,       64'd0);
    check("abort_d_rdata",   bus.d_rdata,         64'd0);
    check("abort_if_rdata",  bus.if_rdata,        64'd0);
    check("abort_busy",      {63'd0, bus.busy},   64'd0);
    check("abort_owner",     {63'd0, bus.owner},  64'd0);
    check("abort_acks",      {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
    step(); t1 = cyc;
    bus.if_req = 1; bus.if_addr = 32'h0;
    exp_q.push_back(mk(0, t1 + 3, 64'hC0DE_0000_FFFF_FFFF, 1));
    repeat (3) step();
    bus.if_req = 0;
    step();

    // Back-to-back fetches at MEM_LAT=1 and MEM_LAT=5.
    step(); t0 = cyc;
    fork
      begin
        bus1.if_addr = 32'h200; bus1.if_req = 1;
        for (int k = 0; k < 3; k++) q1.push_back(mk(0, t0 + 2 + 3 * k, 64'hC0DE_0200_FFFF_FDFF, 1));
        repeat (9) step();
        bus1.if_req = 0;
      end
      begin
        bus5.if_addr = 32'h300; bus5.if_req = 1;
        for (int k = 0; k < 3; k++) q5.push_back(mk(0, t0 + 6 + 7 * k, 64'hC0DE_0300_FFFF_FCFF, 1));
        repeat (21) step();
        bus5.if_req = 0;
      end
    join

    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && q1.size() == 0 && q5.size() == 0) break;
      step();
    end
    if (exp_q.size() != 0) fail_now("drain_main_acks_missing");
    if (q1.size() != 0)    fail_now("drain_lat1_acks_missing");
    if (q5.size() != 0)    fail_now("drain_lat5_acks_missing");
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IR load path) and the data requester (ld/sd path) of the multicycle core.
- Sits between the control-unit-driven datapath and the memory model.
- Serializes accesses, sequences the memory's fixed read latency and returns a one-cycle ack per access.
- Lets the core run with one physical memory instead of separate instruction and data memories.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 64, data width (doubleword ld/sd).
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req=1
- if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched word (registered)
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1=store, 0=load; stable while d_req=1
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; data access complete
- d_rdata  out  DATA_W  load data (registered)
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_addr is presented and held
- busy  out  1  high whenever state != IDLE
- owner  out  1  0=fetch, 1=data; owner of the current or last access

Behaviour:
- Reset values: state=IDLE; all outputs 0, including if_rdata/d_rdata, mem_addr, mem_wdata and owner.
- Reset mid-access aborts it: mem_we drops on the next edge and no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, select a winner (see arbitration) and latch its addr, we and wdata.
  - Load cnt=MEM_LAT for a read, cnt=1 for a write; set owner; go to BUSY.
  - A fetch is always a read.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_we=1 only in the first BUSY cycle of a write; 0 otherwise.
  - cnt decrements each cycle.
  - When cnt==1, capture mem_rdata into the owner's rdata register (reads only); go to RESP.
- RESP: pulse the owner's ack for exactly one cycle, then go to IDLE unconditionally.
- Latency, from the request cycle in IDLE:
  - read ack in cycle MEM_LAT+1
  - write ack in cycle 2
  - MEM_LAT=2: read 3 cycles, store 2 cycles.
  - Minimum spacing between grants: IDLE is revisited after every access.
- Arbitration (default): fixed priority, data over fetch. A pending fetch waits while d_req is high in IDLE.
- The non-owner's rdata register holds its old value. Only one ack is ever high per cycle.
- Requester drops req before its ack: the access still completes and the ack is still issued. The latched values remain in use; req/addr changes during BUSY are ignored.
- Both reqs rise in the same cycle: the arbitration rule applies; the loser is granted in the IDLE after the winner's RESP.
- mem_addr holds its last value while in IDLE; mem_we is always 0 outside the first write cycle of BUSY.
- An MEM_LAT value outside 1..15 is a configuration error and is flagged by an elaboration-time assertion.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_owner register, reset to fetch.
  - When both reqs are high in IDLE, grant the requester that is not last_owner.
  - A single req is granted immediately.
- MEM_ARB_RR_EN undefined: fixed data-over-fetch priority; no last_owner register.

Decomposition:
- Package proc_mem_pkg holds:
  - state enum arb_state_t {IDLE, BUSY, RESP}
  - owner enum owner_t {OWN_IF=0, OWN_D=1}
  - localparam CNT_W=4
  - shared ADDR_W/DATA_W defaults.
- One sub-module is natural: mem_lat_counter, a loadable down-counter with an is_one flag and synchronous reset. The FSM, request latches and response registers stay in the top module.

Test Plan:
- Single load, MEM_LAT=2: d_req=1, d_we=0, d_addr=0x40, memory returns 0xDEAD_BEEF_0000_0001 → d_ack in cycle 3 with d_rdata=0xDEAD_BEEF_0000_0001; if_ack stays 0; busy high for cycles 1–2.
- Single store: d_req=1, d_we=1, d_addr=0x80, d_wdata=0x1234 → mem_we high for exactly cycle 1 with mem_addr=0x80 and mem_wdata=0x1234; d_ack in cycle 2.
- Simultaneous requests, macro undefined: if_req and d_req rise together → data is served first (owner=1, d_ack cycle 3), then fetch (if_ack cycle 7); if_rdata untouched until then.
- MEM_ARB_RR_EN defined, both reqs held continuously over 4 accesses → grant order fetch, data, fetch, data; each ack pulses once per access.
- Reset in the first BUSY cycle of a store → no d_ack ever pulses; all outputs 0 on the next cycle; a following fetch to 0x0 completes normally with if_ack in cycle 3.
- MEM_LAT=1 and MEM_LAT=5 sweep of back-to-back fetches → if_ack every MEM_LAT+2 cycles; no cycle has both acks high.
